// File: rtl/sat_counter_ctrl.sv
// Saturating up/down counter driven by two active-low async buttons, with round-robin tie-break and post-apply lockout.
// Latency: press to count update is 4 clk edges (+DEBOUNCE_CYCLES when SAT_CTRL_DEBOUNCE_EN is defined).
// Backpressure: one pending request per button; repeat presses while pending, or during APPLY/HOLD, are absorbed into the flag.
module sat_counter_ctrl #(
    parameter int WIDTH           = 2,
    parameter int HOLD_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_inc,
    input  logic             btn_dec,
    output logic [WIDTH-1:0] count,
    output logic             led_r,
    output logic             led_g,
    output logic             busy,
    output logic             sat_hit
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, APPLY, HOLD} state_t;

    // Bit 0 carries the inc button, bit 1 the dec button throughout.
    logic [1:0] sync1, sync2, filt, edge_q, press;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {btn_dec, btn_inc};
            sync2 <= sync1;
        end
    end

`ifdef SAT_CTRL_DEBOUNCE_EN
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [DW-1:0] deb_cnt [2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt       <= '1;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (int'(deb_cnt[i]) >= DEBOUNCE_CYCLES - 1) begin
                    filt[i]    <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign filt = sync2;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) edge_q <= '1;
        else        edge_q <= filt;
    end

    assign press = edge_q & ~filt;

    state_t        state, state_nxt;
    logic [HW-1:0] hold_cnt;
    logic          inc_pend, dec_pend;
    logic          last_dec;
    logic          serve_inc;
    logic          pick_inc;
    logic          clr_inc, clr_dec;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (inc_pend || dec_pend) state_nxt = APPLY;
            APPLY:   state_nxt = (HOLD_CYCLES == 0) ? IDLE : HOLD;
            HOLD:    if (hold_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // On a tie, serve whichever type did not go last.
    assign pick_inc = (inc_pend && dec_pend) ? last_dec : inc_pend;
    assign clr_inc  = (state == APPLY) && serve_inc;
    assign clr_dec  = (state == APPLY) && !serve_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            inc_pend  <= 1'b0;
            dec_pend  <= 1'b0;
            last_dec  <= 1'b1;
            serve_inc <= 1'b0;
            count     <= '0;
            sat_hit   <= 1'b0;
        end else begin
            state    <= state_nxt;
            sat_hit  <= 1'b0;
            inc_pend <= (inc_pend & ~clr_inc) | press[0];
            dec_pend <= (dec_pend & ~clr_dec) | press[1];

            if (state == IDLE) serve_inc <= pick_inc;

            if (state == APPLY)
                hold_cnt <= HOLD_LOAD;
            else if (state == HOLD && hold_cnt != '0)
                hold_cnt <= hold_cnt - 1'b1;

            if (state == APPLY) begin
                last_dec <= !serve_inc;
                if (serve_inc) begin
                    if (count != MAX) count <= count + 1'b1;
                    else              sat_hit <= 1'b1;
                end else begin
                    if (count != '0)  count <= count - 1'b1;
                    else              sat_hit <= 1'b1;
                end
            end
        end
    end

    assign led_r = (count == MAX);
    assign led_g = (count == '0);
    assign busy  = (state == APPLY) || (state == HOLD);

endmodule

// File: tb/tb_sat_counter_ctrl.sv
// Directed bench for sat_counter_ctrl at WIDTH=2, HOLD_CYCLES=4; debounce scenario added when SAT_CTRL_DEBOUNCE_EN is defined.
module tb_sat_counter_ctrl;

`ifdef SAT_CTRL_DEBOUNCE_EN
    localparam int DEB = 3;
`else
    localparam int DEB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_inc = 1'b1;
    logic       btn_dec = 1'b1;
    logic [1:0] count;
    logic       led_r, led_g, busy, sat_hit;

    int n_checks = 0;
    int n_pass   = 0;

    sat_counter_ctrl #(.WIDTH(2), .HOLD_CYCLES(4), .DEBOUNCE_CYCLES(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_inc (btn_inc),
        .btn_dec (btn_dec),
        .count   (count),
        .led_r   (led_r),
        .led_g   (led_g),
        .busy    (busy),
        .sat_hit (sat_hit)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        btn_inc = 1'b1;
        btn_dec = 1'b1;
        step(2);
        rst_n = 1'b1;
    endtask

    // Drives the selected buttons low for low_len edges and traces the response over win edges.
    task automatic do_press(input bit pi, input bit pd, input int low_len, input int win,
                            output int sats, output int rises, output int first_val);
        logic       pb;
        logic [1:0] pc;
        sats = 0; rises = 0; first_val = -1;
        pb = busy; pc = count;
        btn_inc = ~pi;
        btn_dec = ~pd;
        for (int i = 0; i < win; i++) begin
            if (i == low_len) begin btn_inc = 1'b1; btn_dec = 1'b1; end
            step(1);
            if (sat_hit === 1'b1) sats++;
            if (busy === 1'b1 && pb !== 1'b1) rises++;
            if (count !== pc && first_val < 0) first_val = int'(count);
            pb = busy; pc = count;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn_inc = 1'b1; btn_dec = 1'b1;
        step(2);
        n_checks++; if (count !== 2'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
        n_checks++; if (led_g !== 1'b1) $display("FAIL reset_led_g got %b want 1", led_g); else n_pass++;
        n_checks++; if (led_r !== 1'b0) $display("FAIL reset_led_r got %b want 0", led_r); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (sat_hit !== 1'b0) $display("FAIL reset_sat_hit got %b want 0", sat_hit); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_first_inc();
        int first = -1;
        int nb = 0;
        step(1);
        btn_inc = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i == 5) btn_inc = 1'b1;
            step(1);
            if (busy === 1'b1) nb++;
            if (count === 2'd1 && first < 0) first = i;
        end
        n_checks++; if (first !== 4 + DEB) $display("FAIL first_latency got edge %0d want %0d", first, 4 + DEB); else n_pass++;
        n_checks++; if (nb !== 5) $display("FAIL first_busy_len got %0d want 5", nb); else n_pass++;
        n_checks++; if (count !== 2'd1) $display("FAIL first_count got %0d want 1", count); else n_pass++;
        n_checks++; if (led_g !== 1'b0) $display("FAIL first_led_g got %b want 0", led_g); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL first_idle got busy %b want 0", busy); else n_pass++;
    endtask

    task automatic test_saturate();
        int exp_cnt [4] = '{1, 2, 3, 3};
        int exp_sat [4] = '{0, 0, 0, 1};
        int s, r, f;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            do_press(1'b1, 1'b0, 4, 30, s, r, f);
            n_checks++; if (int'(count) !== exp_cnt[k]) $display("FAIL sat_count[%0d] got %0d want %0d", k, count, exp_cnt[k]); else n_pass++;
            n_checks++; if (s !== exp_sat[k]) $display("FAIL sat_pulse[%0d] got %0d want %0d", k, s, exp_sat[k]); else n_pass++;
            if (k == 2) begin
                n_checks++; if (led_r !== 1'b1) $display("FAIL sat_led_r got %b want 1", led_r); else n_pass++;
            end
        end
    endtask

    task automatic test_dec_floor();
        int s, r, f;
        do_reset();
        do_press(1'b0, 1'b1, 4, 30, s, r, f);
        n_checks++; if (count !== 2'd0) $display("FAIL floor_count got %0d want 0", count); else n_pass++;
        n_checks++; if (s !== 1) $display("FAIL floor_sat_pulse got %0d want 1", s); else n_pass++;
        n_checks++; if (r !== 1) $display("FAIL floor_apply_count got %0d want 1", r); else n_pass++;
    endtask

    task automatic test_tie();
        int s, r, f;
        do_reset();
        do_press(1'b1, 1'b0, 4, 30, s, r, f);
        do_press(1'b1, 1'b0, 4, 30, s, r, f);
        do_press(1'b0, 1'b1, 4, 30, s, r, f);
        // last served is dec here, so the tie goes to inc first
        do_press(1'b1, 1'b1, 4, 36, s, r, f);
        n_checks++; if (f !== 2) $display("FAIL tie1_first got %0d want 2", f); else n_pass++;
        n_checks++; if (r !== 2) $display("FAIL tie1_applies got %0d want 2", r); else n_pass++;
        n_checks++; if (count !== 2'd1) $display("FAIL tie1_final got %0d want 1", count); else n_pass++;
        do_press(1'b1, 1'b0, 4, 30, s, r, f);
        // last served is now inc, so dec wins this tie
        do_press(1'b1, 1'b1, 4, 36, s, r, f);
        n_checks++; if (f !== 1) $display("FAIL tie2_first got %0d want 1", f); else n_pass++;
        n_checks++; if (r !== 2) $display("FAIL tie2_applies got %0d want 2", r); else n_pass++;
        n_checks++; if (count !== 2'd2) $display("FAIL tie2_final got %0d want 2", count); else n_pass++;
    endtask

`ifndef SAT_CTRL_DEBOUNCE_EN
    task automatic test_hold_drop();
        logic pb;
        int   r = 0;
        do_reset();
        pb = busy;
        for (int i = 0; i < 26; i++) begin
            btn_inc = (i == 0 || i == 1 || i == 4 || i == 5 || i == 7 || i == 8) ? 1'b0 : 1'b1;
            step(1);
            if (busy === 1'b1 && pb !== 1'b1) r++;
            pb = busy;
        end
        n_checks++; if (count !== 2'd2) $display("FAIL drop_count got %0d want 2", count); else n_pass++;
        n_checks++; if (r !== 2) $display("FAIL drop_applies got %0d want 2", r); else n_pass++;
    endtask
`endif

    task automatic test_reset_mid();
        logic pb;
        int   r = 0;
        do_reset();
        btn_inc = 1'b0; btn_dec = 1'b0;
        for (int i = 0; i <= 5 + DEB; i++) begin
            if (i == 4) begin btn_inc = 1'b1; btn_dec = 1'b1; end
            step(1);
        end
        n_checks++; if (count !== 2'd1) $display("FAIL mid_pre_count got %0d want 1", count); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL mid_pre_busy got %b want 1", busy); else n_pass++;
        rst_n = 1'b0;
        step(1);
        n_checks++; if (count !== 2'd0) $display("FAIL mid_rst_count got %0d want 0", count); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", busy); else n_pass++;
        rst_n = 1'b1;
        pb = busy;
        for (int i = 0; i < 25; i++) begin
            step(1);
            if (busy === 1'b1 && pb !== 1'b1) r++;
            pb = busy;
        end
        n_checks++; if (r !== 0) $display("FAIL mid_late_applies got %0d want 0", r); else n_pass++;
        n_checks++; if (count !== 2'd0) $display("FAIL mid_late_count got %0d want 0", count); else n_pass++;
    endtask

    task automatic test_hold_across_reset();
        logic pb;
        int   r = 0;
        rst_n = 1'b0;
        btn_dec = 1'b1;
        btn_inc = 1'b0;
        step(3);
        rst_n = 1'b1;
        pb = busy;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (busy === 1'b1 && pb !== 1'b1) r++;
            pb = busy;
        end
        btn_inc = 1'b1;
        step(10);
        n_checks++; if (count !== 2'd1) $display("FAIL held_count got %0d want 1", count); else n_pass++;
        n_checks++; if (r !== 1) $display("FAIL held_applies got %0d want 1", r); else n_pass++;
    endtask

`ifdef SAT_CTRL_DEBOUNCE_EN
    task automatic test_debounce();
        int s, r, f;
        do_reset();
        do_press(1'b1, 1'b0, 4, 30, s, r, f);
        do_press(1'b1, 1'b0, 4, 30, s, r, f);
        do_press(1'b0, 1'b1, 2, 30, s, r, f);
        n_checks++; if (r !== 0) $display("FAIL glitch_applies got %0d want 0", r); else n_pass++;
        n_checks++; if (count !== 2'd2) $display("FAIL glitch_count got %0d want 2", count); else n_pass++;
        do_press(1'b0, 1'b1, 6, 30, s, r, f);
        n_checks++; if (r !== 1) $display("FAIL deb_applies got %0d want 1", r); else n_pass++;
        n_checks++; if (count !== 2'd1) $display("FAIL deb_count got %0d want 1", count); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_first_inc();
        test_saturate();
        test_dec_floor();
        test_tie();
`ifndef SAT_CTRL_DEBOUNCE_EN
        test_hold_drop();
`endif
        test_reset_mid();
        test_hold_across_reset();
`ifdef SAT_CTRL_DEBOUNCE_EN
        test_debounce();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sat_counter_ctrl.md
SAT_COUNTER_CTRL -- requirements
Module: sat_counter_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 2: counter width in bits; MAX = 2^WIDTH-1.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4: lockout cycles after each applied request; 0 is legal.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 3: stability window used only under SAT_CTRL_DEBOUNCE_EN.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: one clock; reset is synchronous and active-low.
REQ-006 SHALL have port btn_inc, input, 1: increment button, active-low and asynchronous to clk.
REQ-007 SHALL have port btn_dec, input, 1: decrement button, active-low and asynchronous to clk.
REQ-008 SHALL have port count, output, WIDTH: saturating counter value, registered.
REQ-009 SHALL have port led_r, output, 1: high when count == MAX.
REQ-010 SHALL have port led_g, output, 1: high when count == 0.
REQ-011 SHALL have port busy, output, 1: high while FSM is in APPLY or HOLD.
REQ-012 SHALL have port sat_hit, output, 1: one-cycle pulse when an applied request is blocked by saturation.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer; a press is a 1->0 transition of the synchronized (or filtered) level.
REQ-014 SHALL set flag inc_pend or dec_pend on the cycle after a press is detected; a press while its flag is already set is dropped (no accumulation).
REQ-015 SHALL implement FSM states IDLE, APPLY, HOLD; IDLE -> APPLY when any flag is set; APPLY -> HOLD after one cycle; HOLD -> IDLE after HOLD_CYCLES cycles; APPLY -> IDLE directly when HOLD_CYCLES == 0.
REQ-016 SHALL, on entering APPLY with both flags set, serve the request type not served last (round-robin); last_served resets to "dec", so inc wins the first tie.
REQ-017 SHALL in APPLY update count: inc -> count+1 if count < MAX else unchanged; dec -> count-1 if count > 0 else unchanged; no wrap-around ever.
REQ-018 SHALL clear the served flag in APPLY; the unserved flag persists and is served after HOLD.
REQ-019 SHALL pulse sat_hit for the APPLY cycle whose request leaves count unchanged; APPLY and HOLD timing is unaffected.
REQ-020 SHALL keep latching presses into flags during APPLY and HOLD.
REQ-021 SHALL, with the FSM in IDLE, no flags set and the macro undefined, show a new count 4 clk edges after the edge that first samples the button low (sync 2, flag 1, APPLY 1).
REQ-022 SHALL derive led_r, led_g and busy combinationally from registered state only.

Reset
REQ-023 SHALL, while rst_n is low at a clk edge, force count=0, flags=0, FSM=IDLE, last_served=dec, sat_hit=0, and synchronizer and edge-detect flops to 1 (released).
REQ-024 SHALL give outputs during reset of led_g=1, led_r=0, busy=0.
REQ-025 SHALL abandon any in-progress APPLY or HOLD when reset is asserted mid-operation, with no count update.
REQ-026 SHALL register exactly one press for a button held low across reset release.

Configuration
REQ-027 SHALL, when macro SAT_CTRL_DEBOUNCE_EN is defined, change each filtered button level only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; press latency grows by DEBOUNCE_CYCLES.
REQ-028 SHALL, when SAT_CTRL_DEBOUNCE_EN is undefined, use the synchronized level as the filtered level, with DEBOUNCE_CYCLES having no effect and no filter logic present.

Verification (WIDTH=2, HOLD_CYCLES=4, macro undefined unless stated)
REQ-029 SHALL cover: reset, then btn_inc pulsed low 5 cycles -> count 0->1 at 4th edge; busy high 5 cycles; led_g falls.
REQ-030 SHALL cover: 4 separated inc presses -> count 1,2,3,3; 4th press gives sat_hit one pulse; led_r=1 from count=3.
REQ-031 SHALL cover: btn_inc and btn_dec fall on the same edge from count=1 -> inc applied first (count 2), dec after HOLD (count 1); exactly two APPLY cycles.
REQ-032 SHALL cover: 3 inc presses within one HOLD window -> only one extra increment applied (flag dropped repeats).
REQ-033 SHALL cover: rst_n low during HOLD with dec_pend set -> count=0, busy=0 next edge; no later dec applied.
REQ-034 SHALL cover: macro defined, DEBOUNCE_CYCLES=3, 2-cycle low glitch on btn_dec -> no press; 6-cycle low -> exactly one decrement.
